range_merger: RTL and testbench

- Sits directly downstream of the pair-sort stage and consumes its sorted 8-pair blocks (`ARR_8_FLAT_WIDTH` flat bus of tuple_pair_t {first, second}).
- Each pair is an inclusive range [first, second]. The block walks the stream one lane per cycle and coalesces overlapping ranges into a running interval.
- Emits each finished merged range and accumulates the total count of covered IDs.
- On the final block it flushes the open interval and reports the total.

---
 rtl/range_merger.sv | 194 +++++++++++++++++++
 tb/tb_range_merger.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/range_merger.sv
// range_merger: walks sorted 8-pair blocks one lane per cycle, coalesces overlapping inclusive ranges,
// emits each finished range and totals covered IDs. Define RANGE_MERGE_ADJ_EN to also merge touching ranges.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ARR_8_FLAT_WIDTH
`define ARR_8_FLAT_WIDTH (8*2*`DATA_WIDTH)
`endif
`ifndef INDEX_FLAT
`define INDEX_FLAT(flat, i) flat[(i)*2*`DATA_WIDTH +: 2*`DATA_WIDTH]
`endif

module range_merger #(
    parameter int TOTAL_WIDTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [`ARR_8_FLAT_WIDTH-1:0] pairs_in_flat,
    input  logic [7:0]                   lane_mask_in,
    input  logic                         last_in,
    output logic                         range_valid,
    output logic [`DATA_WIDTH-1:0]       range_first,
    output logic [`DATA_WIDTH-1:0]       range_second,
    output logic                         done,
    output logic [TOTAL_WIDTH-1:0]       total_out
);

    localparam int DW = `DATA_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef struct packed {
        logic [DW-1:0] first;
        logic [DW-1:0] second;
    } tuple_pair_t;

    logic [1:0]                   state_q, state_d;
    logic [2:0]                   lane_idx_q, lane_idx_d;
    logic                         cur_valid_q, cur_valid_d;
    logic [DW-1:0]                cur_lo_q, cur_lo_d;
    logic [DW-1:0]                cur_hi_q, cur_hi_d;
    logic                         range_valid_q, range_valid_d;
    logic [DW-1:0]                range_first_q, range_first_d;
    logic [DW-1:0]                range_second_q, range_second_d;
    logic                         done_q, done_d;
    logic                         done_seen_q, done_seen_d;
    logic [TOTAL_WIDTH-1:0]       total_q, total_d;

    logic [`ARR_8_FLAT_WIDTH-1:0] pairs_q;
    logic [7:0]                   mask_q;
    logic                         last_q;

    logic                         accept;
    tuple_pair_t                  lane_pair;
    logic                         lane_en;
    logic                         do_merge;
    logic                         emit;
    logic [DW-1:0]                emit_lo;
    logic [DW-1:0]                emit_hi;
    logic [TOTAL_WIDTH-1:0]       emit_len;

    assign accept = valid_in && (state_q == ST_IDLE);

    always_comb begin
        // NOTE: every signal written here is defaulted first, so no path can infer a latch.
        state_d        = state_q;
        lane_idx_d     = lane_idx_q;
        cur_valid_d    = cur_valid_q;
        cur_lo_d       = cur_lo_q;
        cur_hi_d       = cur_hi_q;
        range_valid_d  = 1'b0;
        range_first_d  = range_first_q;
        range_second_d = range_second_q;
        done_d         = 1'b0;
        done_seen_d    = done_seen_q;
        total_d        = total_q;
        emit           = 1'b0;
        emit_lo        = cur_lo_q;
        emit_hi        = cur_hi_q;
        emit_len       = '0;

        lane_pair = `INDEX_FLAT(pairs_q, lane_idx_q);
        lane_en   = mask_q[lane_idx_q] && (lane_pair.first <= lane_pair.second);
`ifdef RANGE_MERGE_ADJ_EN
        // One extra bit keeps cur_hi+1 from wrapping when cur_hi is all-ones.
        do_merge  = ({1'b0, lane_pair.first} <= ({1'b0, cur_hi_q} + {{DW{1'b0}}, 1'b1}));
`else
        do_merge  = (lane_pair.first <= cur_hi_q);
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_SCAN;
                    lane_idx_d = 3'd0;
                    if (done_seen_q) begin
                        total_d     = '0;
                        done_seen_d = 1'b0;
                    end
                end
            end
            ST_SCAN: begin
                if (lane_en) begin
                    if (!cur_valid_q) begin
                        cur_valid_d = 1'b1;
                        cur_lo_d    = lane_pair.first;
                        cur_hi_d    = lane_pair.second;
                    end else if (do_merge) begin
                        cur_hi_d = (lane_pair.second > cur_hi_q) ? lane_pair.second : cur_hi_q;
                    end else begin
                        emit     = 1'b1;
                        cur_lo_d = lane_pair.first;
                        cur_hi_d = lane_pair.second;
                    end
                end
                lane_idx_d = lane_idx_q + 3'd1;
                if (lane_idx_q == 3'd7) begin
                    state_d = last_q ? ST_FLUSH : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                emit        = cur_valid_q;
                cur_valid_d = 1'b0;
                state_d     = ST_DONE;
            end
            default: begin
                done_d      = 1'b1;
                done_seen_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase

        if (emit) begin
            // Zero-extended so [0, all-ones] counts 2^DW without overflow.
            emit_len       = TOTAL_WIDTH'(emit_hi) - TOTAL_WIDTH'(emit_lo) + TOTAL_WIDTH'(1);
            range_valid_d  = 1'b1;
            range_first_d  = emit_lo;
            range_second_d = emit_hi;
            total_d        = total_q + emit_len;
        end
    end

    // NOTE: capture registers hold payload only and need no reset; they are read solely after an accept loads them.
    always_ff @(posedge clock) begin
        if (accept) begin
            pairs_q <= pairs_in_flat;
            mask_q  <= lane_mask_in;
            last_q  <= last_in;
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            lane_idx_q     <= 3'd0;
            cur_valid_q    <= 1'b0;
            cur_lo_q       <= '0;
            cur_hi_q       <= '0;
            range_valid_q  <= 1'b0;
            range_first_q  <= '0;
            range_second_q <= '0;
            done_q         <= 1'b0;
            done_seen_q    <= 1'b0;
            total_q        <= '0;
        end else begin
            state_q        <= state_d;
            lane_idx_q     <= lane_idx_d;
            cur_valid_q    <= cur_valid_d;
            cur_lo_q       <= cur_lo_d;
            cur_hi_q       <= cur_hi_d;
            range_valid_q  <= range_valid_d;
            range_first_q  <= range_first_d;
            range_second_q <= range_second_d;
            done_q         <= done_d;
            done_seen_q    <= done_seen_d;
            total_q        <= total_d;
        end
    end

    assign ready_in     = (state_q == ST_IDLE);
    assign range_valid  = range_valid_q;
    assign range_first  = range_first_q;
    assign range_second = range_second_q;
    assign done         = done_q;
    assign total_out    = total_q;

endmodule

// File: tb/tb_range_merger.sv
// Testbench for range_merger: directed scenarios plus random streams, checked every cycle
// against a list-based interval-merge model scheduled by clock-edge number.

`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ARR_8_FLAT_WIDTH
`define ARR_8_FLAT_WIDTH (8*2*`DATA_WIDTH)
`endif

module tb_range_merger;

    localparam int     DW   = `DATA_WIDTH;
    localparam int     TW   = 64;
    localparam longint ALL1 = (longint'(1) << DW) - 1;

    logic                         clock = 1'b0;
    logic                         reset = 1'b1;
    logic                         valid_in = 1'b0;
    logic                         ready_in;
    logic [`ARR_8_FLAT_WIDTH-1:0] pairs_in_flat = '0;
    logic [7:0]                   lane_mask_in = '0;
    logic                         last_in = 1'b0;
    logic                         range_valid;
    logic [DW-1:0]                range_first;
    logic [DW-1:0]                range_second;
    logic                         done;
    logic [TW-1:0]                total_out;

    range_merger #(.TOTAL_WIDTH(TW)) dut (
        .clock         (clock),
        .reset         (reset),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .pairs_in_flat (pairs_in_flat),
        .lane_mask_in  (lane_mask_in),
        .last_in       (last_in),
        .range_valid   (range_valid),
        .range_first   (range_first),
        .range_second  (range_second),
        .done          (done),
        .total_out     (total_out)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt = edge_cnt + 1;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint lo;
        longint hi;
    } rng_t;

    longint blk_f[8];
    longint blk_s[8];

    longint exp_lo[int];
    longint exp_hi[int];
    bit     exp_done[int];
    longint exp_tot[int];

    longint cur_tot;
    int     busy_start;
    int     busy_end;

    bit     m_cv;
    longint m_lo;
    longint m_hi;
    longint m_total;
    bit     m_done_seen;
    rng_t   model_q[$];

    int     dut_ranges;
    int     last_acc;

    task automatic model_reset();
        m_cv        = 1'b0;
        m_lo        = 0;
        m_hi        = 0;
        m_total     = 0;
        m_done_seen = 1'b0;
        cur_tot     = 0;
        busy_start  = -100;
        busy_end    = -100;
        exp_lo.delete();
        exp_hi.delete();
        exp_done.delete();
        exp_tot.delete();
    endtask

    task automatic model_emit(input int e, input longint lo, input longint hi);
        rng_t r;
        r.lo = lo;
        r.hi = hi;
        exp_lo[e] = lo;
        exp_hi[e] = hi;
        m_total   = m_total + (hi - lo + 1);
        exp_tot[e] = m_total;
        model_q.push_back(r);
    endtask

    function automatic bit model_merges(input longint f);
`ifdef RANGE_MERGE_ADJ_EN
        return f <= m_hi + 1;
`else
        return f <= m_hi;
`endif
    endfunction

    // Block accepted on edge acc; lane k resolves on edge acc+1+k, flush on acc+9, done on acc+10.
    task automatic model_accept(input int acc, input logic [7:0] mask, input bit last);
        busy_start = acc;
        busy_end   = last ? acc + 9 : acc + 7;
        if (m_done_seen) begin
            m_total      = 0;
            exp_tot[acc] = 0;
            m_done_seen  = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            if (mask[k] && blk_f[k] <= blk_s[k]) begin
                if (!m_cv) begin
                    m_cv = 1'b1;
                    m_lo = blk_f[k];
                    m_hi = blk_s[k];
                end else if (model_merges(blk_f[k])) begin
                    if (blk_s[k] > m_hi) m_hi = blk_s[k];
                end else begin
                    model_emit(acc + 1 + k, m_lo, m_hi);
                    m_lo = blk_f[k];
                    m_hi = blk_s[k];
                end
            end
        end
        if (last) begin
            if (m_cv) model_emit(acc + 9, m_lo, m_hi);
            m_cv = 1'b0;
            exp_done[acc + 10] = 1'b1;
            m_done_seen = 1'b1;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (reset) begin
            check("rst_ready_in", ready_in, 1);
            check("rst_range_valid", range_valid, 0);
            check("rst_done", done, 0);
            check("rst_total_out", total_out, 0);
        end else begin
            if (exp_tot.exists(edge_cnt)) cur_tot = exp_tot[edge_cnt];
            check("ready_in", ready_in, (edge_cnt < busy_start) || (edge_cnt > busy_end));
            check("range_valid", range_valid, exp_lo.exists(edge_cnt));
            if (exp_lo.exists(edge_cnt)) begin
                check("range_first", range_first, exp_lo[edge_cnt]);
                check("range_second", range_second, exp_hi[edge_cnt]);
            end
            check("done", done, exp_done.exists(edge_cnt));
            check("total_out", total_out, cur_tot);
            if (range_valid) dut_ranges = dut_ranges + 1;
        end
    end

    // ---------------- drivers ----------------
    task automatic randomize_inputs();
        for (int w = 0; w < `ARR_8_FLAT_WIDTH / 32; w++) pairs_in_flat[w*32 +: 32] = $urandom;
        lane_mask_in = 8'($urandom);
        last_in      = 1'($urandom);
    endtask

    task automatic send_block(input logic [7:0] mask, input bit last);
        logic [`ARR_8_FLAT_WIDTH-1:0] flat;
        int waited;
        for (int k = 0; k < 8; k++) flat[k*2*DW +: 2*DW] = {DW'(blk_f[k]), DW'(blk_s[k])};
        waited = 0;
        @(negedge clock);
        while (!ready_in && waited < 64) begin
            @(negedge clock);
            waited++;
        end
        if (waited >= 64) begin
            check("ready_timeout", 0, 1);
        end else begin
            last_acc      = edge_cnt + 1;
            valid_in      = 1'b1;
            pairs_in_flat = flat;
            lane_mask_in  = mask;
            last_in       = last;
            model_accept(last_acc, mask, last);
            @(negedge clock);
            valid_in = 1'b0;
            randomize_inputs();
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (edge_cnt < last_acc + 11 && n < 40) begin
            @(negedge clock);
            n++;
        end
    endtask

    task automatic set_pairs(input longint f[8], input longint s[8]);
        for (int k = 0; k < 8; k++) begin
            blk_f[k] = f[k];
            blk_s[k] = s[k];
        end
    endtask

    task automatic start_test();
        dut_ranges = 0;
        model_q.delete();
        for (int k = 0; k < 8; k++) begin
            blk_f[k] = longint'($urandom_range(0, 500));
            blk_s[k] = longint'($urandom_range(0, 500));
        end
    endtask

    initial begin
        longint f[8];
        longint s[8];
        longint base;
        longint cur;
        int     nblk;
        logic [7:0] mask;

        model_reset();
        dut_ranges = 0;
        last_acc   = 0;
        repeat (3) @(negedge clock);
        #1 reset = 1'b0;

        // Basic coalescing in one last block.
        start_test();
        f = '{3, 10, 12, 16, 25, 30, 40, 40};
        s = '{5, 14, 18, 20, 30, 30, 40, 45};
        set_pairs(f, s);
        send_block(8'hFF, 1'b1);
        wait_done();
        check("t1_total", total_out, 26);
        check("t1_dut_ranges", dut_ranges, 4);
        check("t1_model_count", model_q.size(), 4);
        if (model_q.size() == 4) begin
            check("t1_model_r1_lo", model_q[1].lo, 10);
            check("t1_model_r1_hi", model_q[1].hi, 20);
            check("t1_model_r3_hi", model_q[3].hi, 45);
        end

        // Open interval carried across blocks.
        start_test();
        blk_f[0] = 1; blk_s[0] = 4;
        blk_f[1] = 2; blk_s[1] = 9;
        send_block(8'h03, 1'b0);
        start_test();
        blk_f[0] = 5; blk_s[0] = 12;
        send_block(8'h01, 1'b1);
        wait_done();
        check("t2_total", total_out, 12);
        check("t2_dut_ranges", dut_ranges, 1);

        // Touching ranges.
        start_test();
        blk_f[0] = 1; blk_s[0] = 2;
        blk_f[1] = 3; blk_s[1] = 4;
        blk_f[2] = 5; blk_s[2] = 5;
        send_block(8'h07, 1'b1);
        wait_done();
        check("t3_total", total_out, 5);
`ifdef RANGE_MERGE_ADJ_EN
        check("t3_dut_ranges", dut_ranges, 1);
`else
        check("t3_dut_ranges", dut_ranges, 3);
`endif

        // Full-width range plus a malformed lane.
        start_test();
        blk_f[0] = 0; blk_s[0] = ALL1;
        blk_f[1] = 9; blk_s[1] = 3;
        send_block(8'h03, 1'b1);
        wait_done();
        check("t4_total", total_out, longint'(1) << DW);
        check("t4_dut_ranges", dut_ranges, 1);

        // Reset on the 4th SCAN cycle, then a fresh stream.
        start_test();
        for (int k = 0; k < 8; k++) begin
            blk_f[k] = k + 1;
            blk_s[k] = k + 10;
        end
        send_block(8'hFF, 1'b1);
        while (edge_cnt < last_acc + 3) @(negedge clock);
        #1 reset = 1'b1;
        model_reset();
        @(negedge clock);
        #1 reset = 1'b0;
        repeat (14) @(negedge clock);
        check("t5_total_after_rst", total_out, 0);
        check("t5_dut_ranges", dut_ranges, 0);
        start_test();
        blk_f[0] = 7; blk_s[0] = 7;
        send_block(8'h01, 1'b1);
        wait_done();
        check("t5_total_fresh", total_out, 1);

        // Empty last block.
        start_test();
        send_block(8'h00, 1'b1);
        wait_done();
        check("t6_total", total_out, 0);
        check("t6_dut_ranges", dut_ranges, 0);

        // Random streams.
        for (int st = 0; st < 40; st++) begin
            start_test();
            nblk = $urandom_range(1, 4);
            base = ($urandom_range(0, 7) == 0) ? ALL1 - 40 : longint'($urandom_range(0, 100));
            cur  = base;
            for (int b = 0; b < nblk; b++) begin
                for (int k = 0; k < 8; k++) begin
                    cur = cur + longint'($urandom_range(0, 3));
                    if (cur > ALL1) cur = ALL1;
                    blk_f[k] = cur;
                    blk_s[k] = cur + longint'($urandom_range(0, 9)) - 2;
                    if (blk_s[k] > ALL1) blk_s[k] = ALL1;
                    if (blk_s[k] < 0) blk_s[k] = 0;
                end
                mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
                send_block(mask, b == nblk - 1);
                repeat ($urandom_range(0, 2)) @(negedge clock);
            end
            wait_done();
            check("rand_total", total_out, m_total);
        end

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
